// File: rtl/uart8_rx_oversampled.sv
// Purpose : 8N1 UART receiver that oversamples the line and takes a 3-sample majority vote at
//           mid-bit. Each byte is handed over through a one-entry valid/ready holding register.
// Latency : outValid rises about 9.56 bit periods after the start edge.
//           That is mid-stop, plus 2 clk of synchroniser, plus 1 clk of commit.
// Backpr. : a byte that completes while the holding register is full and not being read is
//           dropped, and overrun pulses.
// Ports   : clk, rstN (async active-low), en (receiver enable), rx (async serial line, idle high)
//           out/outValid/outReady (byte handshake), busy (frame in progress)
//           err (framing/parity error pulse), overrun (dropped-byte pulse)
// Option  : define UART8_RX_PARITY_EN to insert an even-parity bit between data and stop (8E1).
module uart8_rx_oversampled #(
  parameter int CLOCK_RATE = 12000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic       en,
  input  logic       rx,
  output logic [7:0] out,
  output logic       outValid,
  input  logic       outReady,
  output logic       busy,
  output logic       err,
  output logic       overrun
);

  localparam int DIV = CLOCK_RATE / (BAUD_RATE * OVERSAMPLE);
  localparam int DW  = $clog2(DIV + 1);
  localparam int SW  = $clog2(OVERSAMPLE);

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [SW-1:0] S_V0     = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_V1     = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_V2     = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] S_LAST   = SW'(OVERSAMPLE - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd3;
  localparam logic [2:0] BREAK  = 3'd4;
`ifdef UART8_RX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd5;
`endif

  logic [1:0]    sync_q;
  logic [DW-1:0] div_q,    div_d;
  logic [SW-1:0] s_q,      s_d;
  logic [2:0]    state_q,  state_d;
  logic [2:0]    bit_q,    bit_d;
  logic [7:0]    shift_q,  shift_d;
  logic [1:0]    samp_q,   samp_d;
  logic          commit_q, commit_d;
  logic          err_q,    err_d;
  logic          ovr_q,    ovr_d;
  logic [7:0]    out_q,    out_d;
  logic          vld_q,    vld_d;
`ifdef UART8_RX_PARITY_EN
  logic          bad_q,    bad_d;   // parity already failed this frame: suppress commit and second err
`endif

  logic rxs, tick, vote, accept;

  assign rxs    = sync_q[1];
  assign tick   = en && (div_q == DIV_LAST);
  // The third vote sample is the live synchronised line at the deciding tick.
  assign vote   = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs) | (samp_q[1] & rxs);
  assign accept = vld_q && outReady;

  always_comb begin
    div_d    = (!en || tick) ? '0 : div_q + 1'b1;
    s_d      = s_q;
    state_d  = state_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    samp_d   = samp_q;
    commit_d = 1'b0;
    err_d    = 1'b0;
`ifdef UART8_RX_PARITY_EN
    bad_d    = bad_q;
`endif

    if (!en) begin
      state_d = IDLE;
      s_d     = '0;
      bit_d   = '0;
    end else if (tick) begin
      if (s_q == S_V0) samp_d[0] = rxs;
      if (s_q == S_V1) samp_d[1] = rxs;
      s_d = (s_q == S_LAST) ? '0 : s_q + 1'b1;

      case (state_q)
        IDLE: begin
          s_d = '0;
          if (!rxs) begin
            // This tick counts as sample 0 of the start bit.
            state_d = START;
            s_d     = SW'(1);
            bit_d   = '0;
`ifdef UART8_RX_PARITY_EN
            bad_d   = 1'b0;
`endif
          end
        end
        START: begin
          if (s_q == S_V2 && vote) begin
            state_d = IDLE;     // glitch, not a start bit
            s_d     = '0;
          end else if (s_q == S_LAST) begin
            state_d = DATA;
          end
        end
        DATA: begin
          if (s_q == S_V2) shift_d = {vote, shift_q[7:1]};
          if (s_q == S_LAST) begin
            if (bit_q == 3'd7) begin
`ifdef UART8_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
        end
`ifdef UART8_RX_PARITY_EN
        PARITY: begin
          if (s_q == S_V2 && ((^shift_q) ^ vote)) begin
            err_d = 1'b1;
            bad_d = 1'b1;
          end
          if (s_q == S_LAST) state_d = STOP;
        end
`endif
        STOP: begin
          // Decide at mid-stop so the next start edge can be caught early.
          if (s_q == S_V2) begin
            s_d = '0;
            if (vote) begin
              state_d  = IDLE;
`ifdef UART8_RX_PARITY_EN
              commit_d = !bad_q;
`else
              commit_d = 1'b1;
`endif
            end else begin
              state_d = BREAK;
`ifdef UART8_RX_PARITY_EN
              err_d   = !bad_q;
`else
              err_d   = 1'b1;
`endif
            end
          end
        end
        BREAK: begin
          // Hold off until the line goes high so a stuck-low line yields one error only.
          s_d = '0;
          if (rxs) state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          s_d     = '0;
        end
      endcase
    end
  end

  always_comb begin
    out_d = out_q;
    vld_d = vld_q && !accept;
    ovr_d = 1'b0;
    if (commit_q) begin
      if (!vld_q || accept) begin
        out_d = shift_q;
        vld_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      sync_q   <= 2'b11;
      div_q    <= '0;
      s_q      <= '0;
      state_q  <= IDLE;
      bit_q    <= '0;
      shift_q  <= '0;
      samp_q   <= '0;
      commit_q <= 1'b0;
      err_q    <= 1'b0;
      ovr_q    <= 1'b0;
      out_q    <= '0;
      vld_q    <= 1'b0;
`ifdef UART8_RX_PARITY_EN
      bad_q    <= 1'b0;
`endif
    end else begin
      sync_q   <= {sync_q[0], rx};
      div_q    <= div_d;
      s_q      <= s_d;
      state_q  <= state_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      samp_q   <= samp_d;
      commit_q <= commit_d;
      err_q    <= err_d;
      ovr_q    <= ovr_d;
      out_q    <= out_d;
      vld_q    <= vld_d;
`ifdef UART8_RX_PARITY_EN
      bad_q    <= bad_d;
`endif
    end
  end

  assign out      = out_q;
  assign outValid = vld_q;
  assign busy     = (state_q != IDLE);
  assign err      = err_q;
  assign overrun  = ovr_q;

endmodule

// File: doc/uart8_rx_oversampled.md
Name: uart8_rx_oversampled

Overview:
- 8N1 UART receiver: the receive end for the Uart8 transmitter on the same bus wire.
- Oversamples the line at 16x the baud rate and takes a majority vote of three mid-bit samples.
- Delivers each byte through a one-entry valid/ready holding register.
- Reports framing errors and overrun.
- Sits between the pin synchroniser side of the board and any byte consumer (FIFO or command parser).

Parameters:
- CLOCK_RATE, 12000000: system clock frequency in Hz.
- BAUD_RATE, 9600: line bit rate.
- OVERSAMPLE, 16: samples per bit; must be ≥ 8 and even.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rstN  in  1  asynchronous active-low reset.
- en  in  1  receiver enable.
- rx  in  1  serial line, idle high, asynchronous to clk.
- out  out  8  received byte, valid while outValid is high.
- outValid  out  1  holding register full.
- outReady  in  1  consumer accepts the byte when outValid && outReady.
- busy  out  1  frame in progress.
- err  out  1  one-cycle pulse on a framing error (parity error too if the option is compiled in).
- overrun  out  1  one-cycle pulse when a completed byte is dropped.

Behaviour:
- Reset values: out=0, outValid=0, busy=0, err=0, overrun=0. The state machine goes to IDLE, all counters are 0, and both synchroniser flops are 1.
- Reset is asynchronous on assert and takes effect mid-frame. Any partial byte is lost.
- Synchroniser: two flops on rx. All decisions use the second flop (rxS).
- Tick generator: DIV = CLOCK_RATE/(BAUD_RATE*OVERSAMPLE), integer division; 78 at defaults.
  - The counter runs 0..DIV-1 while en=1; tick is high for one cycle when it equals DIV-1.
  - en=0 clears the counter.
- Sample counter s runs 0..OVERSAMPLE-1 on ticks. The vote takes samples at s = OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 (7, 8, 9); the majority of the three is the bit value.
- States:
  - IDLE: on a tick with rxS=0, go to START with s=1.
  - START: at s=OVERSAMPLE/2+1, if the vote is 1 it is a false start: go to IDLE, no err. Otherwise continue. At s wrap (OVERSAMPLE-1 → 0), go to DATA with bit index 0.
  - DATA: vote each bit. Shift LSB first into the shift register. At s wrap after bit 7, go to STOP.
  - STOP: decided at s=OVERSAMPLE/2+1, mid-stop, for early resync.
    - Vote 1: commit the byte and go to IDLE.
    - Vote 0: pulse err for one cycle, discard the byte and go to BREAK.
  - BREAK: wait for a tick with rxS=1, then go to IDLE. This prevents a held-low line from producing repeated frames.
- busy = 1 in START, DATA, STOP and BREAK; 0 in IDLE.
- Commit (the cycle after the deciding tick):
  - If outValid=0, or outValid && outReady in the same cycle: load out and set outValid=1.
  - Otherwise keep the old byte, drop the new one and pulse overrun.
- Handshake: outValid clears on the cycle after outValid && outReady, unless a commit reloads it in that same cycle. out is stable while outValid=1.
- en=0:
  - Forces IDLE within one cycle and clears the tick and sample counters; no err.
  - The holding register and outValid are unaffected; the handshake still works.
- Frame latency: outValid rises about 9.56 bit periods after the start edge (mid-stop plus the synchroniser delay of 2 clk).
- Worst-case tolerance at defaults: ±3% baud mismatch.

Optional Feature:
- Macro UART8_RX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP, voted like a data bit. The frame is 11 bits.
  - Even parity: if XOR(data, parity bit) is not 0, pulse err at the parity decision and discard the byte.
  - The FSM then still waits for the stop bit and goes through STOP, or BREAK if the stop bit is 0.
  - At most one err pulse per frame.
- Undefined: no PARITY state; frames are 10 bits (8N1). The behaviour above applies unchanged.

Test Plan:
- Bit period at defaults is 1248 clk.
- Scenario 1: drive 8'b01111010 as 8N1 at 1248 clk/bit with outReady=1 → outValid pulses one cycle with out=8'h7A, err=0, overrun=0, busy high for about 9.5 bits.
- Scenario 2: send 8'hB1 then 8'h7A back-to-back with outReady=0 → out=8'hB1 is held, overrun pulses once at the second mid-stop. Raising outReady then → outValid drops the next cycle and out is still 8'hB1.
- Scenario 3: low glitch of 300 clk on an idle line → no state leaves IDLE beyond START, busy is high under 1 bit, outValid=0, err=0.
- Scenario 4: byte 8'h55 with the stop bit driven 0, then the line held low for 3 bit periods → err pulses once, outValid=0, busy stays 1 until rx returns high, then the next 8'h33 frame is received correctly.
- Scenario 5: frames at baud +3% and -3% (1211 and 1285 clk/bit) carrying 8'hA5 → received as 8'hA5 both times.
- Scenario 6: deassert rstN mid-DATA of a frame, release it, then send 8'h0F → all outputs read reset values immediately, the partial frame is lost and 8'h0F is received. With UART8_RX_PARITY_EN, a bad parity bit on 8'h0F → err pulses and outValid stays 0.
